// File: rtl/rr_mux4_arbiter_if.sv
// Handshake bundle between four requesters and the round-robin mux arbiter.
// master drives requests/data, slave returns grant, mux selects and the registered result.
interface rr_mux4_arbiter_if;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic       sel1;
  logic       sel0;
  logic       f;
  logic       f_valid;
  logic       busy;

  modport master (
    output req, din,
    input  gnt, sel1, sel0, f, f_valid, busy
  );

  modport slave (
    input  req, din,
    output gnt, sel1, sel0, f, f_valid, busy
  );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters; grant one cycle after request,
// f/f_valid one cycle after a transfer, grants bounded by HOLD_MAX cycles with no idle gap on handover.
module rr_mux4_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  rr_mux4_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         last_q,  last_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [3:0]         gnt_q,   gnt_d;
  logic [1:0]         sel_q,   sel_d;
  logic               f_q,     f_d;
  logic               f_valid_q, f_valid_d;

  logic               mux_out;
  logic               xfer;
  logic               release_now;
  logic [1:0]         winner;

  // First set request starting at base+1, wrapping around to base itself last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int i = 4; i >= 1; i--) begin
      idx = base + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // Gate-level 4:1 mux driven by the registered selects.
  always_comb begin
    mux_out = (~sel_q[1] & ~sel_q[0] & bus.din[0]) |
              (~sel_q[1] &  sel_q[0] & bus.din[1]) |
              ( sel_q[1] & ~sel_q[0] & bus.din[2]) |
              ( sel_q[1] &  sel_q[0] & bus.din[3]);
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    f_d         = f_q;
    f_valid_d   = 1'b0;
    xfer        = (state_q == GRANT) && gnt_q[sel_q] && bus.req[sel_q];
    release_now = !bus.req[sel_q] || (cnt_q == CNT_W'(HOLD_MAX));
    winner      = rr_pick(bus.req, last_q);

    if (xfer) begin
      f_d       = mux_out;
      f_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (bus.req != 4'b0000) begin
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          cnt_d   = CNT_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          // Re-arbitrate immediately from the released requester so handover has no gap.
          last_d = sel_q;
          winner = rr_pick(bus.req, sel_q);
          if (bus.req != 4'b0000) begin
            gnt_d = 4'b0001 << winner;
            sel_d = winner;
            cnt_d = CNT_W'(1);
          end else begin
            gnt_d   = 4'b0000;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'b00;
      f_q       <= 1'b0;
      f_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      f_q       <= f_d;
      f_valid_q <= f_valid_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel1    = sel_q[1];
  assign bus.sel0    = sel_q[0];
  assign bus.f       = f_q;
  assign bus.f_valid = f_valid_q;
  assign bus.busy    = (state_q == GRANT);

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: reset, rotation, hold-expiry regrant, early release, mid-grant reset.
module tb_rr_mux4_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;
  logic [3:0] dinv;

  always #5 clk = ~clk;

  rr_mux4_arbiter_if bus();

  rr_mux4_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Advance one cycle, sample #1 after the edge, and check the grant/select invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("gnt_onehot0", {3'b000, $onehot0(bus.gnt)}, 4'b0001);
    if (bus.gnt != 4'b0000)
      chk("sel_matches_gnt", bus.gnt, 4'b0001 << {bus.sel1, bus.sel0});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},  bus.gnt, 4'b0000);
    chk({tag, "_sel"},  {2'b00, bus.sel1, bus.sel0}, 4'b0000);
    chk({tag, "_f"},    {3'b000, bus.f}, 4'b0000);
    chk({tag, "_fv"},   {3'b000, bus.f_valid}, 4'b0000);
    chk({tag, "_busy"}, {3'b000, bus.busy}, 4'b0000);
  endtask

  initial begin
    // Reset held two cycles with all requesters active.
    rst      = 1'b1;
    bus.req  = 4'b1111;
    dinv     = 4'b1010;
    bus.din  = dinv;
    tick();
    chk_reset_outputs("rst_c1");
    tick();
    chk_reset_outputs("rst_c2");
    rst = 1'b0;
    tick();
    chk("first_gnt", bus.gnt, 4'b0001);
    chk("first_sel", {2'b00, bus.sel1, bus.sel0}, 4'b0000);
    chk("first_busy", {3'b000, bus.busy}, 4'b0001);
    chk("first_fv", {3'b000, bus.f_valid}, 4'b0000);

    // Full rotation, four cycles per requester, then back to requester 0.
    for (int n = 1; n < 20; n++) begin
      tick();
      chk("rot_gnt", bus.gnt, 4'b0001 << ((n / 4) % 4));
      chk("rot_fv", {3'b000, bus.f_valid}, 4'b0001);
      chk("rot_f", {3'b000, bus.f}, {3'b000, dinv[((n - 1) / 4) % 4]});
    end

    // All requests drop while requester 0 holds: back to IDLE.
    bus.req = 4'b0000;
    tick();
    chk("idle_gnt", bus.gnt, 4'b0000);
    chk("idle_busy", {3'b000, bus.busy}, 4'b0000);
    chk("idle_fv", {3'b000, bus.f_valid}, 4'b0000);

    // Single requester 2 re-granted continuously across hold expiry.
    rst = 1'b1;
    tick();
    chk_reset_outputs("rst_t2");
    rst     = 1'b0;
    bus.req = 4'b0100;
    bus.din = 4'b0100;
    tick();
    chk("solo_gnt", bus.gnt, 4'b0100);
    chk("solo_sel", {2'b00, bus.sel1, bus.sel0}, 4'b0010);
    chk("solo_fv0", {3'b000, bus.f_valid}, 4'b0000);
    for (int n = 0; n < 11; n++) begin
      tick();
      chk("solo_hold_gnt", bus.gnt, 4'b0100);
      chk("solo_f", {3'b000, bus.f}, 4'b0001);
      chk("solo_fv", {3'b000, bus.f_valid}, 4'b0001);
      chk("solo_busy", {3'b000, bus.busy}, 4'b0001);
    end

    // Reset in the middle of a grant, then priority restarts at requester 0.
    rst     = 1'b1;
    bus.req = 4'b1111;
    tick();
    chk_reset_outputs("rst_mid");
    rst = 1'b0;
    tick();
    chk("post_rst_gnt", bus.gnt, 4'b0001);

    // Requester 0 releases early; requester 1 takes over with no gap.
    rst     = 1'b1;
    bus.req = 4'b0011;
    bus.din = 4'b0010;
    tick();
    rst = 1'b0;
    tick();
    chk("early_g1", bus.gnt, 4'b0001);
    tick();
    chk("early_g2", bus.gnt, 4'b0001);
    chk("early_fv2", {3'b000, bus.f_valid}, 4'b0001);
    chk("early_f2", {3'b000, bus.f}, 4'b0000);
    bus.req = 4'b0010;
    tick();
    chk("early_hand_gnt", bus.gnt, 4'b0010);
    chk("early_hand_sel", {2'b00, bus.sel1, bus.sel0}, 4'b0001);
    chk("early_hand_fv", {3'b000, bus.f_valid}, 4'b0000);
    tick();
    chk("early_r1_fv", {3'b000, bus.f_valid}, 4'b0001);
    chk("early_r1_f", {3'b000, bus.f}, 4'b0001);

    // Requester 0 rejoins after dropping; it is next after requester 1 expires.
    bus.req = 4'b0011;
    tick();
    tick();
    chk("rejoin_hold", bus.gnt, 4'b0010);
    tick();
    chk("rejoin_gnt", bus.gnt, 4'b0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
